// File: rtl/bcd_timer_if.sv
// Bus bundle for the two-digit BCD countdown timer.
// The master drives the controls and the preset. The slave returns the count and status.
interface bcd_timer_if;
   logic       start;
   logic       pause;
   logic       tick;
   logic [7:0] preset;
   logic [3:0] tens;
   logic [3:0] units;
   logic       running;
   logic       done;
   logic       err;
   logic [1:0] state;

   modport master (
      output start, pause, tick, preset,
      input  tens, units, running, done, err, state
   );

   modport slave (
      input  start, pause, tick, preset,
      output tens, units, running, done, err, state
   );
endinterface

// File: rtl/bcd_timer_controller.sv
// Two-digit BCD countdown timer with the states IDLE, RUN, PAUSED and FINISHED.
// done and err are registered one-cycle pulses.
module bcd_timer_controller (
   input  logic        clk,
   input  logic        clear,
   bcd_timer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      RUN      = 2'b01,
      PAUSED   = 2'b10,
      FINISHED = 2'b11
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] tens_reg, tens_next;
   logic [3:0] units_reg, units_next;
   logic       done_reg, done_next;
   logic       err_reg, err_next;
   logic       load_req;

   // A preset is accepted only when every nibble is a legal BCD digit.
   logic [1:0] nibble_ok;
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_nibble
         assign nibble_ok[gi] = (bus.preset[gi*4 +: 4] <= 4'd9);
      end
   endgenerate

   logic preset_valid;
   logic preset_zero;
   assign preset_valid = &nibble_ok;
   assign preset_zero  = (bus.preset == 8'h00);

   // Decrement with borrow. The count can never go below 00, so no code outside 0-9 is produced.
   logic       count_zero;
   logic       dec_zero;
   logic [3:0] dec_tens;
   logic [3:0] dec_units;
   assign count_zero = (tens_reg == 4'd0) && (units_reg == 4'd0);
   assign dec_zero   = (tens_reg == 4'd0) && (units_reg == 4'd1);
   assign dec_units  = (units_reg != 4'd0) ? units_reg - 4'd1 : 4'd9;
   assign dec_tens   = (units_reg != 4'd0) ? tens_reg : tens_reg - 4'd1;

   // State, count and pulse registers. clear takes priority over every other input.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_reg <= IDLE;
         tens_reg  <= 4'd0;
         units_reg <= 4'd0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         tens_reg  <= tens_next;
         units_reg <= units_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
      end
   end

   // Next-state, count and pulse logic. A load request is resolved after the state decode.
   always_comb begin
      state_next = state_reg;
      tens_next  = tens_reg;
      units_next = units_reg;
      done_next  = 1'b0;
      err_next   = 1'b0;
      load_req   = 1'b0;

      case (state_reg)
         IDLE, FINISHED: begin
            load_req = bus.start;
         end
         RUN: begin
            // pause wins over start and over tick in the same cycle.
            if (bus.pause) begin
               state_next = PAUSED;
            end else if (bus.start) begin
               load_req = 1'b1;
            end else if (bus.tick && !count_zero) begin
               tens_next  = dec_tens;
               units_next = dec_units;
               if (dec_zero) begin
                  state_next = FINISHED;
                  done_next  = 1'b1;
               end
            end
         end
         PAUSED: begin
            // Resuming keeps the frozen count. Only start without pause leaves this state.
            if (bus.start && !bus.pause) begin
               state_next = RUN;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (load_req) begin
         if (!preset_valid) begin
            // An invalid preset leaves the count and the state untouched.
            err_next = 1'b1;
         end else begin
            tens_next  = bus.preset[7:4];
            units_next = bus.preset[3:0];
            if (preset_zero) begin
               state_next = FINISHED;
               done_next  = 1'b1;
            end else begin
               state_next = RUN;
            end
         end
      end
   end

   assign bus.tens    = tens_reg;
   assign bus.units   = units_reg;
   assign bus.state   = state_reg;
   assign bus.running = (state_reg == RUN);
   assign bus.done    = done_reg;
   assign bus.err     = err_reg;

endmodule

// File: tb/tb_bcd_timer_controller.sv
// Bench for bcd_timer_controller. The directed stimulus pushes expected responses into a scoreboard queue.
// A separate monitor pops an entry on the falling edge after each checked cycle and compares it with the outputs.
module tb_bcd_timer_controller;

   logic clk = 1'b0;
   logic clear;
   always #5 clk = ~clk;

   bcd_timer_if bus ();

   bcd_timer_controller dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   // The expected word is {state, tens, units, running, done, err}.
   logic [12:0] exp_q[$];
   string       name_q[$];
   int          total = 0;
   int          bad = 0;
   bit          stim_done = 1'b0;

   localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSED = 2'b10, S_FIN = 2'b11;

   function automatic logic [7:0] bcd(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   // Drive the inputs for one cycle. After the edge, queue the response expected from it.
   task automatic cyc(input logic c, input logic s, input logic p, input logic t,
                      input logic [7:0] pre, input logic [1:0] st, input logic [7:0] cnt,
                      input logic dn, input logic er, input string nm);
      clear      = c;
      bus.start  = s;
      bus.pause  = p;
      bus.tick   = t;
      bus.preset = pre;
      @(posedge clk);
      #1;
      exp_q.push_back({st, cnt, (st == S_RUN), dn, er});
      name_q.push_back(nm);
      @(negedge clk);
      #1;
   endtask

   // Monitor: owns the counters, the drain timeout and the summary line.
   logic [12:0] mon_exp, mon_act;
   string       mon_name;
   int          mon_cycles = 0;
   initial begin
      forever begin
         @(negedge clk);
         mon_cycles++;
         if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {bus.state, bus.tens, bus.units, bus.running, bus.done, bus.err};
            total++;
            if (mon_act !== mon_exp) begin
               bad++;
               $display("FAIL %s: got state=%b count=%h run=%b done=%b err=%b, want state=%b count=%h run=%b done=%b err=%b",
                        mon_name, mon_act[12:11], mon_act[10:3], mon_act[2], mon_act[1], mon_act[0],
                        mon_exp[12:11], mon_exp[10:3], mon_exp[2], mon_exp[1], mon_exp[0]);
            end else begin
               $display("ok %s: state=%b count=%h run=%b done=%b err=%b",
                        mon_name, mon_act[12:11], mon_act[10:3], mon_act[2], mon_act[1], mon_act[0]);
            end
         end else if (stim_done) begin
            break;
         end
         if (mon_cycles > 2000) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d cycles, want completion within 2000", mon_cycles);
            break;
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      clear = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0; bus.preset = 8'h00;
      @(negedge clk);
      #1;
      //  clr st pa tk preset  state     count  dn er
      cyc(1, 0, 0, 0, 8'h00, S_IDLE,   8'h00, 0, 0, "reset");

      // Count down from 12 to 00. The 10->09 step checks the borrow.
      cyc(0, 1, 0, 0, 8'h12, S_RUN,    8'h12, 0, 0, "load12");
      for (int i = 1; i <= 11; i++)
         cyc(0, 0, 0, 1, 8'h00, S_RUN, bcd(12 - i), 0, 0, "count");
      cyc(0, 0, 0, 1, 8'h00, S_FIN,    8'h00, 1, 0, "reach00_done");
      cyc(0, 0, 0, 0, 8'h00, S_FIN,    8'h00, 0, 0, "done_one_cycle");

      // FINISHED ignores ticks and never wraps to 99.
      for (int i = 0; i < 5; i++)
         cyc(0, 0, 0, 1, 8'h00, S_FIN, 8'h00, 0, 0, "fin_no_wrap");
      cyc(0, 1, 0, 0, 8'h03, S_RUN,    8'h03, 0, 0, "fin_reload03");

      // Pause at 05. pause beats a same-cycle tick, and resuming keeps the count.
      cyc(0, 1, 0, 0, 8'h05, S_RUN,    8'h05, 0, 0, "restart05");
      cyc(0, 0, 1, 1, 8'h00, S_PAUSED, 8'h05, 0, 0, "pause_over_tick");
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 1, 1, 8'h00, S_PAUSED, 8'h05, 0, 0, "paused_tick");
      cyc(0, 1, 1, 0, 8'h42, S_PAUSED, 8'h05, 0, 0, "paused_start_pause");
      cyc(0, 1, 0, 0, 8'h42, S_RUN,    8'h05, 0, 0, "resume_no_reload");
      cyc(0, 0, 0, 1, 8'h00, S_RUN,    8'h04, 0, 0, "resume_tick");

      // Restart from RUN at 08 with 20, then borrow 20->19.
      cyc(0, 1, 0, 0, 8'h08, S_RUN,    8'h08, 0, 0, "restart08");
      cyc(0, 1, 0, 1, 8'h20, S_RUN,    8'h20, 0, 0, "restart20_tick_ignored");
      cyc(0, 0, 0, 1, 8'h00, S_RUN,    8'h19, 0, 0, "tick_to19");
      cyc(0, 0, 0, 0, 8'h00, S_RUN,    8'h19, 0, 0, "no_tick_hold");
      cyc(0, 1, 0, 0, 8'h3F, S_RUN,    8'h19, 0, 1, "run_invalid_err");
      cyc(0, 0, 0, 0, 8'h00, S_RUN,    8'h19, 0, 0, "err_one_cycle");

      // clear mid-count overrides tick and start and gives no done pulse.
      cyc(0, 1, 0, 0, 8'h07, S_RUN,    8'h07, 0, 0, "load07");
      cyc(1, 1, 0, 1, 8'h07, S_IDLE,   8'h00, 0, 0, "clear_midcount");
      cyc(0, 0, 0, 0, 8'h00, S_IDLE,   8'h00, 0, 0, "after_clear");

      // Invalid preset from IDLE, then a zero preset that goes straight to FINISHED.
      cyc(0, 1, 0, 0, 8'h1A, S_IDLE,   8'h00, 0, 1, "idle_invalid_err");
      cyc(0, 0, 0, 0, 8'h1A, S_IDLE,   8'h00, 0, 0, "idle_err_cleared");
      cyc(0, 1, 0, 0, 8'h00, S_FIN,    8'h00, 1, 0, "idle_zero_done");
      cyc(0, 0, 0, 0, 8'h00, S_FIN,    8'h00, 0, 0, "zero_done_one_cycle");

      stim_done = 1'b1;
   end

endmodule

// File: doc/bcd_timer_controller.md
BCD_TIMER_CONTROLLER -- requirements
Module: bcd_timer_controller

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 clear  input  1  synchronous active-high reset.
REQ-004 start  input  1  level; load preset and run, or resume from pause.
REQ-005 pause  input  1  level; freeze counting.
REQ-006 preset  input  8  BCD preset: [7:4] tens, [3:0] units.
REQ-007 tick  input  1  one-cycle count-enable strobe; at most one decrement per tick.
REQ-008 tens  output  4  BCD tens digit of the current count.
REQ-009 units  output  4  BCD units digit of the current count.
REQ-010 running  output  1  high exactly while in state RUN.
REQ-011 done  output  1  one-cycle pulse when the count reaches 00.
REQ-012 err  output  1  one-cycle pulse on an invalid-preset load attempt.
REQ-013 state  output  2  state code: IDLE=00, RUN=01, PAUSED=10, FINISHED=11.

Function
REQ-014 Load: on a start-triggered load, {tens,units} SHALL take preset at that edge, and running SHALL be high from the next cycle.
REQ-015 Preset validity: a preset is valid only if both nibbles are <=9; an invalid preset SHALL leave the count and state unchanged and pulse err for 1 cycle.
REQ-016 IDLE: start=1 with a valid nonzero preset -> load, go to RUN.
REQ-017 IDLE or FINISHED: start=1 with preset=00 -> load 00, go to FINISHED, pulse done for 1 cycle.
REQ-018 RUN, on tick=1 with pause=0: units>0 -> units-1; units=0 -> units=9 and tens-1 (borrow).
REQ-019 RUN: a decrement that yields 00 SHALL move to FINISHED on the same edge, and done SHALL be high for exactly the following cycle.
REQ-020 RUN: tick=0 -> count held.
REQ-021 RUN: pause=1 -> go to PAUSED, count held; pause SHALL override a same-cycle tick, which is discarded.
REQ-022 RUN: start=1 with pause=0 -> restart (reload preset per REQ-014/015, tick ignored that cycle); invalid preset -> err, keep running with the count unchanged.
REQ-023 PAUSED: tick ignored; start=1 and pause=0 -> RUN with the count unchanged; start=1 and pause=1 -> stay PAUSED.
REQ-024 FINISHED: count held at 00; tick ignored; start=1 -> reload per REQ-014/015/017.
REQ-025 Wrap-around: the count SHALL never decrement below 00; tens=0, units=0 SHALL NOT wrap to 99.
REQ-026 Digits SHALL always hold BCD values 0-9; no non-BCD code is ever produced internally.
REQ-027 done and err SHALL never be high in consecutive cycles from a single event.

Reset
REQ-028 clear=1 at a rising edge SHALL force state=IDLE, tens=0, units=0, running=0, done=0, err=0, overriding all other inputs.
REQ-029 clear asserted in any state, including mid-count, SHALL abort the operation; no done pulse SHALL be generated.
REQ-030 After clear deasserts, the block SHALL respond to start on the first following edge.

Verification
REQ-031 Reset then start with preset=0x12, then 12 ticks -> count 11,10,09,...,01,00; 10->09 borrow correct; done pulses once after the 12th tick; state=11.
REQ-032 RUN at 05: pause=1 together with tick -> count stays 05, state=10; 3 ticks -> still 05; start -> state=01; next tick -> 04.
REQ-033 IDLE, preset=0x1A then start -> err pulse, state=00, count 00; preset=0x00 then start -> state=11, done pulse.
REQ-034 FINISHED plus 5 extra ticks -> count stays 00, no wrap to 99; start with preset=0x03 -> RUN at 03.
REQ-035 RUN at 07, clear=1 for 1 cycle together with tick and start -> state=00, count 00, done=0, running=0.
REQ-036 RUN at 08, start with preset=0x20 -> count 20 next cycle, state=01; one tick -> 19.
